// File: rtl/computer_pkg.sv
// Shared types and constants for the computer top level.
// Program-memory window and loader FSM encoding.
package computer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FINISH,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [7:0] PROG_BASE = 8'h00;
    localparam logic [7:0] PROG_TOP  = 8'h7F;

endpackage

// File: rtl/program_loader.sv
// Streams a host byte image into program memory over valid/ready,
// holding the CPU in reset until the whole image has been written.
module program_loader
    import computer_pkg::*;
#(
    parameter int          PROG_DEPTH = int'(PROG_TOP) - int'(PROG_BASE) + 1,
    parameter int          ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(PROG_BASE)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] load_address,
    output logic [7:0]        load_data,
    output logic              load_write,
    output logic              cpu_reset_n,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] byte_count,
    output logic [7:0]        checksum
);

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(PROG_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(PROG_DEPTH - 1);

    loader_state_t     state, state_d;
    logic [ADDR_W-1:0] count_d, addr_d;
    logic [7:0]        sum_d, data_d;
    logic              write_d, done_d, error_d, cpu_d;
    logic              accept;

    assign in_ready = (state == LOAD) && ({1'b0, byte_count} < DEPTH_X);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state;
        count_d = byte_count;
        sum_d   = checksum;
        addr_d  = load_address;
        data_d  = load_data;
        write_d = 1'b0;
        done_d  = done;
        error_d = error;
        cpu_d   = cpu_reset_n;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                    sum_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    cpu_d   = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    write_d = 1'b1;
                    addr_d  = BASE_ADDR + byte_count;
                    data_d  = in_data;
                    count_d = byte_count + ADDR_W'(1);
                    sum_d   = checksum + in_data;
                    if (in_last) begin
                        state_d = FINISH;
                    end else if (byte_count == LAST_SLOT) begin
                        // Depth used up without an end marker: image rejected.
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            FINISH: begin
                state_d = DONE;
                done_d  = 1'b1;
                cpu_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            byte_count   <= '0;
            checksum     <= '0;
            load_address <= '0;
            load_data    <= '0;
            load_write   <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_reset_n  <= 1'b0;
        end else begin
            state        <= state_d;
            byte_count   <= count_d;
            checksum     <= sum_d;
            load_address <= addr_d;
            load_data    <= data_d;
            load_write   <= write_d;
            done         <= done_d;
            error        <= error_d;
            cpu_reset_n  <= cpu_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of per-cycle vectors
// plus hand-written reset, overflow and mid-load reset sequences.
module tb_program_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [7:0] load_address;
    logic [7:0] load_data;
    logic       load_write;
    logic       cpu_reset_n;
    logic       done;
    logic       error;
    logic [7:0] byte_count;
    logic [7:0] checksum;

    int tests = 0;
    int fails = 0;

    program_loader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .load_address (load_address),
        .load_data    (load_data),
        .load_write   (load_write),
        .cpu_reset_n  (cpu_reset_n),
        .done         (done),
        .error        (error),
        .byte_count   (byte_count),
        .checksum     (checksum)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       st;
        logic       vld;
        logic [7:0] dat;
        logic       lst;
        logic       rdy;
        logic       wr;
        logic [7:0] wa;
        logic [7:0] wd;
        logic [7:0] cnt;
        logic [7:0] sum;
        logic       dn;
        logic       er;
        logic       cpu;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic st, input logic vld, input logic [7:0] dat,
                     input logic lst, input logic rdy, input logic wr,
                     input logic [7:0] wa, input logic [7:0] wd,
                     input logic [7:0] cnt, input logic [7:0] sum,
                     input logic dn, input logic er, input logic cpu);
        vec_t e;
        e.st = st; e.vld = vld; e.dat = dat; e.lst = lst;
        e.rdy = rdy; e.wr = wr; e.wa = wa; e.wd = wd;
        e.cnt = cnt; e.sum = sum; e.dn = dn; e.er = er; e.cpu = cpu;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic vld,
                         input logic [7:0] dat, input logic lst);
        start = st; in_valid = vld; in_data = dat; in_last = lst;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [36:0] obs(input logic wr_exp);
        logic [7:0] a, d;
        a = wr_exp ? load_address : 8'h00;
        d = wr_exp ? load_data : 8'h00;
        return {in_ready, load_write, a, d, byte_count, checksum,
                done, error, cpu_reset_n};
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b1;
        in_data = 8'h55; in_last = 1'b0;

        // Reset held two cycles with in_valid asserted
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs",
            {in_ready, load_write, load_address, load_data, byte_count,
             checksum, done, error, cpu_reset_n}, 37'd0);
        reset = 1'b0; in_valid = 1'b0;

        // Basic back-to-back image
        v(1,0,8'h00,0, 1,0,8'h00,8'h00, 8'd0,8'h00, 0,0,0);
        v(0,1,8'h87,0, 1,1,8'h00,8'h87, 8'd1,8'h87, 0,0,0);
        v(0,1,8'h05,0, 1,1,8'h01,8'h05, 8'd2,8'h8C, 0,0,0);
        v(0,1,8'hF2,1, 0,1,8'h02,8'hF2, 8'd3,8'h7E, 0,0,0);
        v(0,0,8'h00,0, 0,0,8'h00,8'h00, 8'd3,8'h7E, 1,0,1);
        v(0,0,8'h00,0, 0,0,8'h00,8'h00, 8'd3,8'h7E, 1,0,1);
        // Same image with gaps; garbage on data/last while invalid
        v(1,0,8'h00,0, 1,0,8'h00,8'h00, 8'd0,8'h00, 0,0,0);
        v(0,1,8'h87,0, 1,1,8'h00,8'h87, 8'd1,8'h87, 0,0,0);
        v(0,0,8'hAA,1, 1,0,8'h00,8'h00, 8'd1,8'h87, 0,0,0);
        v(0,0,8'h3C,1, 1,0,8'h00,8'h00, 8'd1,8'h87, 0,0,0);
        v(0,1,8'h05,0, 1,1,8'h01,8'h05, 8'd2,8'h8C, 0,0,0);
        v(0,0,8'hFF,1, 1,0,8'h00,8'h00, 8'd2,8'h8C, 0,0,0);
        v(0,1,8'hF2,1, 0,1,8'h02,8'hF2, 8'd3,8'h7E, 0,0,0);
        v(0,0,8'h00,0, 0,0,8'h00,8'h00, 8'd3,8'h7E, 1,0,1);
        // start mid-LOAD and in FINISH is ignored
        v(1,0,8'h00,0, 1,0,8'h00,8'h00, 8'd0,8'h00, 0,0,0);
        v(0,1,8'h11,0, 1,1,8'h00,8'h11, 8'd1,8'h11, 0,0,0);
        v(1,1,8'h22,0, 1,1,8'h01,8'h22, 8'd2,8'h33, 0,0,0);
        v(1,0,8'h00,0, 1,0,8'h00,8'h00, 8'd2,8'h33, 0,0,0);
        v(0,1,8'h33,1, 0,1,8'h02,8'h33, 8'd3,8'h66, 0,0,0);
        v(1,0,8'h00,0, 0,0,8'h00,8'h00, 8'd3,8'h66, 1,0,1);
        // start in DONE re-arms and a second load completes
        v(1,0,8'h00,0, 1,0,8'h00,8'h00, 8'd0,8'h00, 0,0,0);
        v(0,1,8'h01,1, 0,1,8'h00,8'h01, 8'd1,8'h01, 0,0,0);
        v(0,0,8'h00,0, 0,0,8'h00,8'h00, 8'd1,8'h01, 1,0,1);

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].vld, tbl[i].dat, tbl[i].lst);
            chk($sformatf("vec%0d", i), 64'(obs(tbl[i].wr)),
                64'({tbl[i].rdy, tbl[i].wr, tbl[i].wa, tbl[i].wd,
                     tbl[i].cnt, tbl[i].sum, tbl[i].dn, tbl[i].er,
                     tbl[i].cpu}));
        end

        // Overflow: 128 bytes with no end marker
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < 128; i++) begin
            drive(0, 1, 8'(i), 0);
            chk($sformatf("ovf_wr%0d", i),
                {load_write, load_address, load_data},
                {1'b1, 8'(i), 8'(i)});
        end
        chk("ovf_flags", {error, in_ready, cpu_reset_n, done},
            {1'b1, 1'b0, 1'b0, 1'b0});
        chk("ovf_count", {byte_count, checksum}, {8'd128, 8'hC0});
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8'hEE, 1);
            chk($sformatf("ovf_hold%0d", i),
                {load_write, in_ready, error, byte_count},
                {1'b0, 1'b0, 1'b1, 8'd128});
        end

        // Reset after five accepted bytes drops the pending write
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 8'(8'h10 + i), 0);
        chk("mid_cnt", {load_write, load_address, byte_count, checksum},
            {1'b1, 8'h04, 8'd5, 8'h5A});
        reset = 1'b1;
        drive(0, 1, 8'h99, 0);
        chk("mid_reset",
            {in_ready, load_write, load_address, load_data, byte_count,
             checksum, done, error, cpu_reset_n}, 37'd0);
        reset = 1'b0;
        drive(1, 0, 8'h00, 0);
        drive(0, 1, 8'h5A, 1);
        chk("reload_wr", {load_write, load_address, load_data, checksum},
            {1'b1, 8'h00, 8'h5A, 8'h5A});
        drive(0, 0, 8'h00, 0);
        chk("reload_done", {done, cpu_reset_n, error, byte_count},
            {1'b1, 1'b1, 1'b0, 8'd1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
